// File: rtl/axi4_pkg.sv
// axi4_pkg: FSM states, AXI response codes and fixed AXI attribute tie-offs
// shared by axi4_master_bridge and its integration wrapper.
package axi4_pkg;
    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B, RSP} state_e;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [3:0] AXI_ID         = 4'd1;
    localparam logic [7:0] AXI_LEN        = 8'd0;
    localparam logic [2:0] AXI_SIZE       = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic       AXI_WLAST      = 1'b1;
endpackage

// File: rtl/axi4_master_bridge.sv
// axi4_master_bridge: single-outstanding request/response to AXI4 single-beat master.
// Define AXI4_BRIDGE_RESP_CHK_EN to report non-OKAY slave responses on o_rsp_err.
module axi4_master_bridge
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic                i_aclk,
    input  logic                i_areset_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_wen,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic [DATA_W/8-1:0] i_req_wstrb,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_err,
    output logic [ADDR_W-1:0]   o_araddr,
    output logic                o_arvalid,
    input  logic                i_arready,
    input  logic [DATA_W-1:0]   i_rdata,
    input  logic [1:0]          i_rresp,
    input  logic                i_rvalid,
    output logic                o_rready,
    output logic [ADDR_W-1:0]   o_awaddr,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                capture;

    assign capture = (state_q == RD_R && i_rvalid) || (state_q == WR_B && i_bvalid);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: if (i_req_valid) begin
                addr_d    = i_req_addr;
                wdata_d   = i_req_wdata;
                wstrb_d   = i_req_wstrb;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = i_req_wen ? WR_AW_W : RD_AR;
            end
            RD_AR: state_d = i_arready ? RD_R : RD_AR;
            RD_R: if (i_rvalid) begin
                rdata_d = i_rdata;
                state_d = RSP;
            end
            // AW and W complete independently; a done channel keeps its valid low.
            WR_AW_W: begin
                aw_done_d = aw_done_q | i_awready;
                w_done_d  = w_done_q | i_wready;
                state_d   = (aw_done_d && w_done_d) ? WR_B : WR_AW_W;
            end
            WR_B: if (i_bvalid) begin
                rdata_d = '0;
                state_d = RSP;
            end
            RSP: state_d = i_rsp_ready ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

`ifdef AXI4_BRIDGE_RESP_CHK_EN
    logic [1:0] resp_q, resp_d;
    always_comb resp_d = capture ? ((state_q == WR_B) ? i_bresp : i_rresp) : resp_q;
    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) resp_q <= RESP_OKAY;
        else resp_q <= resp_d;
    end
    assign o_rsp_err = resp_q != RESP_OKAY;
`else
    logic unused_resp;
    assign unused_resp = ^{i_rresp, i_bresp, capture};
    assign o_rsp_err   = 1'b0;
`endif

    assign o_req_ready = i_areset_n && state_q == IDLE;
    assign o_arvalid   = state_q == RD_AR;
    assign o_araddr    = addr_q;
    assign o_rready    = state_q == RD_R;
    assign o_awvalid   = state_q == WR_AW_W && !aw_done_q;
    assign o_awaddr    = addr_q;
    assign o_wvalid    = state_q == WR_AW_W && !w_done_q;
    assign o_wdata     = wdata_q;
    assign o_wstrb     = wstrb_q;
    assign o_bready    = state_q == WR_B;
    assign o_rsp_valid = state_q == RSP;
    assign o_rsp_rdata = rdata_q;
endmodule

// File: tb/tb_axi4_master_bridge.sv
// tb_axi4_master_bridge: transaction-level model of the bridge contract plus a
// reactive AXI slave with per-test delay knobs and directed literal checks.
module tb_axi4_master_bridge;
`ifdef AXI4_BRIDGE_RESP_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic i_req_valid = 1'b0, i_req_wen = 1'b0, i_rsp_ready = 1'b0;
    logic [7:0] i_req_addr = '0, i_req_wstrb = '0;
    logic [63:0] i_req_wdata = '0, i_rdata = '0;
    logic i_arready = 1'b0, i_rvalid = 1'b0, i_awready = 1'b0, i_wready = 1'b0, i_bvalid = 1'b0;
    logic [1:0] i_rresp = '0, i_bresp = '0;
    logic o_req_ready, o_rsp_valid, o_rsp_err, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
    logic [63:0] o_rsp_rdata, o_wdata;
    logic [7:0] o_araddr, o_awaddr, o_wstrb;

    always #5 clk = ~clk;

    axi4_master_bridge dut (
        .i_aclk(clk), .i_areset_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_err(o_rsp_err),
        .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
    );

    int tests = 0, fails = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: which AXI phases of the outstanding request are finished.
    bit m_out, m_wr, m_ar, m_r, m_aw, m_w, m_b;
    logic [7:0] m_addr, m_wstrb;
    logic [63:0] m_wdata, m_rdata;
    bit m_err, chk_en = 0, rsp_seen;
    int cyc = 0, acc_cyc = 0, lat = 0;
    int n_arv = 0, n_awv = 0, n_wv = 0, n_rspv = 0, n_bfire = 0;
    logic [63:0] last_rdata;
    logic last_err;

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("req_ready", o_req_ready, rst_n && !m_out);
            chk("arvalid", o_arvalid, m_out && !m_wr && !m_ar);
            chk("rready", o_rready, m_out && !m_wr && m_ar && !m_r);
            chk("awvalid", o_awvalid, m_out && m_wr && !m_aw);
            chk("wvalid", o_wvalid, m_out && m_wr && !m_w);
            chk("bready", o_bready, m_out && m_wr && m_aw && m_w && !m_b);
            chk("rsp_valid", o_rsp_valid, m_out && (m_r || m_b));
            if (o_arvalid) chk("araddr", o_araddr, m_addr);
            if (o_awvalid) chk("awaddr", o_awaddr, m_addr);
            if (o_wvalid) begin
                chk("wdata", o_wdata, m_wdata);
                chk("wstrb", o_wstrb, m_wstrb);
            end
            if (o_rsp_valid) begin
                chk("rsp_rdata", o_rsp_rdata, m_rdata);
                chk("rsp_err", o_rsp_err, m_err);
            end
        end
        if (o_arvalid) n_arv++;
        if (o_awvalid) n_awv++;
        if (o_wvalid) n_wv++;
        if (o_rsp_valid) begin
            n_rspv++;
            last_rdata = o_rsp_rdata;
            last_err = o_rsp_err;
            if (!rsp_seen) begin lat = cyc - acc_cyc; rsp_seen = 1; end
        end
        if (!rst_n) begin
            {m_out, m_wr, m_ar, m_r, m_aw, m_w, m_b} = '0;
        end else begin
            if (o_arvalid && i_arready) m_ar = 1;
            if (o_rready && i_rvalid) begin m_r = 1; m_rdata = i_rdata; m_err = CHK && i_rresp != 2'b00; end
            if (o_awvalid && i_awready) m_aw = 1;
            if (o_wvalid && i_wready) m_w = 1;
            if (o_bready && i_bvalid) begin m_b = 1; m_rdata = '0; m_err = CHK && i_bresp != 2'b00; n_bfire++; end
            if (o_rsp_valid && i_rsp_ready) m_out = 0;
            if (i_req_valid && o_req_ready) begin
                m_out = 1; m_wr = i_req_wen; m_addr = i_req_addr;
                m_wdata = i_req_wdata; m_wstrb = i_req_wstrb;
                {m_ar, m_r, m_aw, m_w, m_b} = '0;
                acc_cyc = cyc; rsp_seen = 0;
            end
        end
    end

    // Reactive slave and response consumer, driven just after each rising edge.
    bit ar_rdy = 1, r_en = 1;
    int aw_wait = 0, w_wait = 0, rsp_wait = 0, aw_cnt = 0, w_cnt = 0, rsp_cnt = 0;
    logic [63:0] s_rdata = '0;
    logic [1:0] s_rresp = '0, s_bresp = '0;

    always @(posedge clk) begin
        #1;
        if (!m_out) begin aw_cnt = 0; w_cnt = 0; rsp_cnt = 0; end
        i_arready = ar_rdy;
        i_awready = m_out && m_wr && !m_aw && aw_cnt >= aw_wait;
        i_wready = m_out && m_wr && !m_w && w_cnt >= w_wait;
        if (m_out && m_wr && !m_aw) aw_cnt++;
        if (m_out && m_wr && !m_w) w_cnt++;
        i_rvalid = m_out && !m_wr && m_ar && !m_r && r_en;
        i_rdata = s_rdata;
        i_rresp = s_rresp;
        i_bvalid = m_out && m_wr && m_aw && m_w && !m_b;
        i_bresp = s_bresp;
        i_rsp_ready = m_out && (m_r || m_b) && rsp_cnt >= rsp_wait;
        if (m_out && (m_r || m_b)) rsp_cnt++;
    end

    task automatic send(input logic wen, input logic [7:0] addr, input logic [63:0] wd, input logic [7:0] ws);
        int n = 0;
        @(posedge clk); #2;
        i_req_valid = 1; i_req_wen = wen; i_req_addr = addr; i_req_wdata = wd; i_req_wstrb = ws;
        @(negedge clk);
        while (!o_req_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_timeout", n >= 20, 0);
        @(posedge clk); #2;
        i_req_valid = 0;
    endtask

    task automatic run_req(input logic wen, input logic [7:0] addr, input logic [63:0] wd, input logic [7:0] ws);
        int n;
        send(wen, addr, wd, ws);
        for (n = 0; n < 200 && m_out; n++) @(posedge clk);
        chk("rsp_timeout", n >= 200, 0);
    endtask

    int a0, aw0, w0, r0, b0;
    task automatic snap();
        a0 = n_arv; aw0 = n_awv; w0 = n_wv; r0 = n_rspv; b0 = n_bfire;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1; chk_en = 1;
        @(negedge clk);
        chk("rst_req_ready", o_req_ready, 1);
        chk("rst_valids", {o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready, o_rsp_valid}, 0);
        chk("rst_data", {o_rsp_rdata, o_araddr, o_rsp_err}, 0);

        s_rdata = 64'h1122_3344_5566_7788; snap();
        run_req(0, 8'h0A, '0, '0);
        chk("rd_latency", lat, 3);
        chk("rd_ar_cycles", n_arv - a0, 1);
        chk("rd_rsp_cycles", n_rspv - r0, 1);
        chk("rd_rdata", last_rdata, 64'h1122_3344_5566_7788);

        aw_wait = 2; snap();
        run_req(1, 8'h10, 64'hDEAD_BEEF, 8'h0F);
        chk("wr_w_cycles", n_wv - w0, 1);
        chk("wr_aw_cycles", n_awv - aw0, 3);
        chk("wr_b_count", n_bfire - b0, 1);
        chk("wr_latency", lat, 5);
        chk("wr_err", last_err, 0);
        chk("wr_rdata_zero", last_rdata, 0);

        aw_wait = 0; w_wait = 2; snap();
        run_req(1, 8'h20, 64'h0123_4567_89AB_CDEF, 8'hFF);
        chk("wr2_w_cycles", n_wv - w0, 3);
        chk("wr2_aw_cycles", n_awv - aw0, 1);
        chk("wr2_latency", lat, 5);
        w_wait = 0;

        rsp_wait = 5; s_rdata = 64'hA5A5_5A5A_0F0F_F0F0; snap();
        run_req(0, 8'h44, '0, '0);
        chk("hold_rsp_cycles", n_rspv - r0, 6);
        chk("hold_rdata", last_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
        rsp_wait = 0;

        s_bresp = 2'b10;
        run_req(1, 8'h58, 64'h1, 8'h01);
        chk("bresp_err", last_err, CHK);
        s_bresp = 2'b00;

        s_rresp = 2'b11; s_rdata = 64'hCAFE;
        run_req(0, 8'h60, '0, '0);
        chk("rresp_err", last_err, CHK);
        chk("rresp_rdata", last_rdata, 64'hCAFE);
        s_rresp = 2'b00;

        r_en = 0;
        send(0, 8'h33, '0, '0);
        @(posedge clk); #2;
        rst_n = 0;
        @(negedge clk);
        chk("mid_rready", o_rready, 1);
        @(posedge clk); #2;
        rst_n = 1; r_en = 1;
        @(negedge clk);
        chk("post_rst_valids", {o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready, o_rsp_valid}, 0);
        chk("post_rst_req_ready", o_req_ready, 1);
        chk("post_rst_araddr", o_araddr, 0);

        s_rdata = '1;
        run_req(0, 8'hFF, '0, '0);
        chk("recover_latency", lat, 3);
        chk("recover_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FFFF);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
